// File: rtl/serial_bridge_pkg.sv
// Shared constants and FSM state encoding for serial_mem_bridge.
package serial_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_GET_ADDR  = 4'd1,
    ST_GET_DATA  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_RD_LAT    = 4'd4,
    ST_SEND      = 4'd5,
    ST_SEND_WAIT = 4'd6,
    ST_RUN       = 4'd7,
    ST_RUN_WAIT  = 4'd8,
    ST_REPLY     = 4'd9
  } state_t;

endpackage

// File: rtl/bridge_timeout.sv
// Loadable down-counter; o_expired flags an enabled counter that has reached zero.
module bridge_timeout #(
  parameter int unsigned LOAD = 100
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(LOAD + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                     r_cnt <= CW'(LOAD);
    else if (i_load)               r_cnt <= CW'(LOAD);
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/serial_mem_bridge.sv
// Command-driven UART byte <-> word memory bridge with write, read-back and processor run.
// Optional inter-byte timeout enabled by defining BRIDGE_TIMEOUT_EN.
module serial_mem_bridge
  import serial_bridge_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_tx_busy,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_send,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_start,
  input  logic              i_proc_busy,
  output logic [3:0]        o_state
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam logic [3:0]  LAST  = 4'(BYTES - 1);

  state_t            r_state, w_next;
  logic [7:0]        r_cmd, r_reply, w_rd_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic [1:0]        r_ign;
  logic              r_rd, r_seen_busy, w_timeout;

`ifdef BRIDGE_TIMEOUT_EN
  logic w_tmo_en, w_tmo_load;
  assign w_tmo_en   = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
  assign w_tmo_load = i_rx_valid || !w_tmo_en;

  bridge_timeout #(.LOAD(TIMEOUT_CYC)) u_timeout (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_load    (w_tmo_load),
    .i_en      (w_tmo_en),
    .o_expired (w_timeout)
  );
`else
  // Parameter stays referenced so the interface is identical in both builds.
  assign w_timeout = (TIMEOUT_CYC == 0) & 1'b0;
`endif

  always_comb begin
    w_rd_byte = '0;
    for (int unsigned k = 0; k < BYTES; k++)
      if (r_cnt == 4'(k)) w_rd_byte = i_mem_rdata[8*k +: 8];
  end

  always_comb begin
    w_next    = r_state;
    o_tx_send = 1'b0;
    o_tx_data = '0;
    o_mem_we  = 1'b0;
    o_start   = 1'b0;
    case (r_state)
      ST_IDLE: if (i_rx_valid) begin
        if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) w_next = ST_GET_ADDR;
        else if (i_rx_data == CMD_GO && !i_proc_busy)        w_next = ST_RUN;
        else                                                  w_next = ST_REPLY;
      end
      ST_GET_ADDR: begin
        if (i_rx_valid)     w_next = (r_cmd == CMD_WRITE) ? ST_GET_DATA : ST_RD_LAT;
        else if (w_timeout) w_next = ST_REPLY;
      end
      ST_GET_DATA: begin
        if (i_rx_valid)     w_next = (r_cnt == LAST) ? ST_WRITE : ST_GET_DATA;
        else if (w_timeout) w_next = ST_REPLY;
      end
      ST_WRITE: begin
        o_mem_we = 1'b1;
        w_next   = ST_REPLY;
      end
      ST_RD_LAT: w_next = ST_SEND;
      ST_SEND: if (!i_tx_busy) begin
        o_tx_send = 1'b1;
        o_tx_data = w_rd_byte;
        w_next    = ST_SEND_WAIT;
      end
      ST_SEND_WAIT: if (r_ign == '0 && !i_tx_busy)
        w_next = (r_rd && r_cnt != LAST) ? ST_SEND : ST_IDLE;
      ST_RUN: begin
        o_start = 1'b1;
        w_next  = ST_RUN_WAIT;
      end
      ST_RUN_WAIT: if (r_seen_busy && !i_proc_busy) w_next = ST_REPLY;
      ST_REPLY: if (!i_tx_busy) begin
        o_tx_send = 1'b1;
        o_tx_data = r_reply;
        w_next    = ST_SEND_WAIT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_reply     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_ign       <= '0;
      r_rd        <= 1'b0;
      r_seen_busy <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (i_rx_valid) begin
          r_cmd       <= i_rx_data;
          r_cnt       <= '0;
          r_rd        <= 1'b0;
          r_seen_busy <= 1'b0;
          r_reply     <= NAK_BYTE;
        end
        ST_GET_ADDR: begin
          if (i_rx_valid) begin
            r_addr <= i_rx_data[ADDR_W-1:0];
            r_rd   <= (r_cmd == CMD_READ);
          end else if (w_timeout) r_reply <= NAK_BYTE;
        end
        ST_GET_DATA: begin
          if (i_rx_valid) begin
            for (int unsigned k = 0; k < BYTES; k++)
              if (r_cnt == 4'(k)) r_wdata[8*k +: 8] <= i_rx_data;
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 4'd1;
          end else if (w_timeout) r_reply <= NAK_BYTE;
        end
        ST_WRITE: r_reply <= ACK_BYTE;
        ST_SEND:  if (!i_tx_busy) r_ign <= 2'd2;
        ST_REPLY: if (!i_tx_busy) r_ign <= 2'd2;
        // Busy is blind for two cycles after a send while Serial raises its flag.
        ST_SEND_WAIT: begin
          if (r_ign != '0) r_ign <= r_ign - 2'd1;
          else if (!i_tx_busy && r_rd && r_cnt != LAST) r_cnt <= r_cnt + 4'd1;
        end
        ST_RUN_WAIT: begin
          if (i_proc_busy) r_seen_busy <= 1'b1;
          if (r_seen_busy && !i_proc_busy) r_reply <= ACK_BYTE;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_state     = r_state;

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Scoreboard bench for serial_mem_bridge: reference memory model, UART/processor/RAM models.
module tb_serial_mem_bridge;
  import serial_bridge_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int BYTES  = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              tx_busy = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              start;
  logic              proc_model_busy = 1'b0;
  logic              force_busy = 1'b0;
  logic              proc_busy;
  logic [3:0]        state;

  assign proc_busy = proc_model_busy | force_busy;

  serial_mem_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(100)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_tx_busy   (tx_busy),
    .o_tx_data   (tx_data),
    .o_tx_send   (tx_send),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata),
    .o_start     (start),
    .i_proc_busy (proc_busy),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the bridge
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model and scoreboard
  logic [DATA_W-1:0]        ref_mem [DEPTH];
  int                       wlist[$];
  logic [7:0]               exp_tx[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr[$];
  int  total = 0, bad = 0;
  int  tx_seen = 0, we_seen = 0, start_seen = 0;
  bit  g_pending = 0;
  time t_ack = 0, t_fall = 0;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_send) begin
        tx_seen++;
        check("tx_while_busy", longint'(tx_busy), 0);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tx: got %02h expected none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          check("tx_byte", longint'(tx_data), longint'(e));
          if (g_pending && e == ACK_BYTE) begin
            g_pending = 0;
            t_ack = $time;
          end
        end
      end
      if (mem_we) begin
        we_seen++;
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got %0h expected none", {mem_addr, mem_wdata});
        end else begin
          logic [ADDR_W+DATA_W-1:0] w;
          w = exp_wr.pop_front();
          check("mem_write", longint'({mem_addr, mem_wdata}), longint'(w));
        end
      end
      if (start) start_seen++;
    end
  end

  // Serial transmitter: busy for a random span after each send
  initial forever begin
    @(negedge clk);
    if (tx_send) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat ($urandom_range(3, 12)) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // Processor: busy for 100 cycles shortly after a start pulse
  initial forever begin
    @(negedge clk);
    if (start) begin
      repeat (3) @(posedge clk);
      #1 proc_model_busy = 1'b1;
      repeat (100) @(posedge clk);
      #1 proc_model_busy = 1'b0;
      t_fall = $time;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || state != 4'd0 || tx_busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL wait_timeout: got state %0d expected idle with empty queues", state);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [DATA_W-1:0] d);
    int a = int'(ab[ADDR_W-1:0]);
    ref_mem[a] = d;
    wlist.push_back(a);
    exp_wr.push_back({ab[ADDR_W-1:0], d});
    exp_tx.push_back(ACK_BYTE);
    send_byte(CMD_WRITE);
    send_byte(ab);
    for (int k = 0; k < BYTES; k++) send_byte(d[8*k +: 8]);
    wait_quiet();
  endtask

  task automatic do_read(input logic [7:0] ab);
    logic [DATA_W-1:0] d = ref_mem[int'(ab[ADDR_W-1:0])];
    for (int k = 0; k < BYTES; k++) exp_tx.push_back(d[8*k +: 8]);
    send_byte(CMD_READ);
    send_byte(ab);
    wait_quiet();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_state"},   longint'(state), 0);
    check({tag, "_tx_send"}, longint'(tx_send), 0);
    check({tag, "_tx_data"}, longint'(tx_data), 0);
    check({tag, "_we"},      longint'(mem_we), 0);
    check({tag, "_addr"},    longint'(mem_addr), 0);
    check({tag, "_wdata"},   longint'(mem_wdata), 0);
    check({tag, "_start"},   longint'(start), 0);
  endtask

  initial begin
    int we0, tx0, st0;
    logic [7:0] b;
    logic [DATA_W-1:0] d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    do_write(8'h03, 32'h1234_5678);
    check("single_we", longint'(we_seen), 1);
    do_read(8'h03);

    exp_tx.push_back(NAK_BYTE);
    send_byte(8'h58);
    wait_quiet();
    check("state_after_nak", longint'(state), 0);
    do_read(8'h13);

    g_pending = 1;
    exp_tx.push_back(ACK_BYTE);
    send_byte(CMD_GO);
    wait_quiet();
    check("start_pulses", longint'(start_seen), 1);
    check("ack_after_busy_fall", longint'(t_ack > t_fall), 1);

    force_busy = 1'b1;
    exp_tx.push_back(NAK_BYTE);
    send_byte(CMD_GO);
    wait_quiet();
    force_busy = 1'b0;
    check("no_start_when_busy", longint'(start_seen), 1);

    we0 = we_seen;
    send_byte(CMD_WRITE);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    check("no_write_after_rst", longint'(we_seen), longint'(we0));
    do_write(8'h01, 32'hCAFE_F00D);
    do_read(8'h01);

`ifdef BRIDGE_TIMEOUT_EN
    we0 = we_seen;
    exp_tx.push_back(NAK_BYTE);
    send_byte(CMD_WRITE);
    send_byte(8'h01);
    repeat (101) @(posedge clk);
    wait_quiet();
    check("no_write_on_timeout", longint'(we_seen), longint'(we0));
`else
    tx0 = tx_seen;
    send_byte(CMD_WRITE);
    send_byte(8'h05);
    repeat (1000) @(posedge clk);
    check("no_tx_while_waiting", longint'(tx_seen), longint'(tx0));
    check("still_get_data", longint'(state), 2);
    d = DATA_W'($urandom);
    ref_mem[5] = d;
    wlist.push_back(5);
    exp_wr.push_back({4'd5, d});
    exp_tx.push_back(ACK_BYTE);
    for (int k = 0; k < BYTES; k++) send_byte(d[8*k +: 8]);
    wait_quiet();
`endif

    st0 = start_seen;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), DATA_W'($urandom));
        1: begin
          b = 8'($urandom);
          b[ADDR_W-1:0] = ADDR_W'(wlist[$urandom_range(0, wlist.size() - 1)]);
          do_read(b);
        end
        default: begin
          b = 8'($urandom);
          if (b == CMD_WRITE || b == CMD_READ || b == CMD_GO) b = 8'h00;
          exp_tx.push_back(NAK_BYTE);
          send_byte(b);
          wait_quiet();
        end
      endcase
    end
    check("no_stray_start", longint'(start_seen), longint'(st0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mem_bridge.md
# serial_mem_bridge

Parametrised command-driven bridge between the byte-level `Serial` UART core and a word-addressed processor data memory. It replaces the fixed 32-bit, 16-entry string loader with generic word width and depth. It adds read-back, explicit run/ACK handshaking with the processor, and NAK on bad commands. It sits in the top-level shell between `Serial` (rx/tx byte ports) and `riscv_casca` (memory load port and busy flag).

## Interface
Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8, 8..64; BYTES = DATA_W/8
- ADDR_W, 4, memory address width; 1..8; depth = 2**ADDR_W
- TIMEOUT_CYC, 50_000_000, inter-byte timeout in clocks (used only with BRIDGE_TIMEOUT_EN)

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_rx_data  in  8  received byte from Serial
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- i_tx_busy  in  1  Serial transmitter busy
- o_tx_data  out  8  byte to transmit
- o_tx_send  out  1  one-cycle send strobe
- o_mem_addr  out  ADDR_W  memory word address
- o_mem_wdata  out  DATA_W  write data
- o_mem_we  out  1  one-cycle write strobe
- i_mem_rdata  in  DATA_W  read data, valid 1 cycle after o_mem_addr (synchronous RAM)
- o_start  out  1  one-cycle processor start pulse
- i_proc_busy  in  1  processor running
- o_state  out  4  FSM state, debug/LEDR

## Operation
- Protocol is half-duplex, command byte first. Bytes arriving outside IDLE/GET_ADDR/GET_DATA are dropped.
- 'W' (0x57), addr, BYTES data bytes little-endian:
  - write mem[addr] with a single o_mem_we pulse
  - then reply 0x06 (ACK)
- 'R' (0x52), addr: reply BYTES bytes of mem[addr], LSB first.
- 'G' (0x47):
  - If i_proc_busy=1 on entry, reply 0x15 (NAK).
  - Otherwise pulse o_start, wait for i_proc_busy high, then low, then reply 0x06.
- Any other command byte: reply 0x15, return to IDLE.
- Address byte: addr = byte[ADDR_W-1:0]; upper bits ignored (0x13 with ADDR_W=4 -> 3).
- Data assembly: byte k goes to wdata[8k+7:8k]; byte counter runs 0..BYTES-1 and resets on each command.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, RD_LAT, SEND, SEND_WAIT, RUN, RUN_WAIT, REPLY.
  - IDLE -'W'/'R'-> GET_ADDR; IDLE -'G'-> RUN or REPLY(NAK); IDLE -other-> REPLY(NAK)
  - GET_ADDR -W-> GET_DATA; GET_ADDR -R-> RD_LAT
  - GET_DATA -last byte-> WRITE -> REPLY(ACK)
  - RD_LAT -> SEND <-> SEND_WAIT, repeated until BYTES bytes are sent -> IDLE
  - RUN (o_start pulse) -> RUN_WAIT -> REPLY(ACK)
  - REPLY -> SEND_WAIT -> IDLE
- Reset values: all outputs 0; o_state=IDLE (0); wdata, counters and address cleared. Reset mid-transaction aborts with no write and no reply.

## Timing
- o_tx_send is asserted only when i_tx_busy=0, with o_tx_data stable in the same cycle.
- After each send, i_tx_busy is ignored for 2 cycles (Serial busy rise latency), then the bridge waits for it to go low.
- Write: o_mem_we asserts the cycle after the last data byte's i_rx_valid; addr and wdata are stable that cycle.
- Read: o_mem_addr is held from RD_LAT through the last send; the first o_tx_send is no earlier than 2 cycles after the addr byte.
- RUN_WAIT: o_start is one cycle wide. The bridge waits indefinitely for i_proc_busy to rise, then to fall.
- i_rx_valid in the same cycle as a state exit is consumed only by the state being exited. No byte is double-counted.

## Configuration
- BRIDGE_TIMEOUT_EN defined:
  - In GET_ADDR/GET_DATA, a counter reloads on each i_rx_valid.
  - After TIMEOUT_CYC idle cycles, the transaction is abandoned without a write and 0x15 is sent.
- BRIDGE_TIMEOUT_EN undefined: no counter; the FSM waits forever for the next byte.

## Structure
- Package serial_bridge_pkg holds:
  - command constants CMD_WRITE/CMD_READ/CMD_GO
  - ACK_BYTE/NAK_BYTE
  - the state enum and its 4-bit encoding
- Sub-module bridge_timeout: loadable down-counter with an expiry flag. It is instantiated only under BRIDGE_TIMEOUT_EN.

## Test plan
- 'W',0x03,0x78,0x56,0x34,0x12 -> exactly one o_mem_we, addr 3, wdata 0x12345678; tx 0x06.
- 'R',0x03 after above -> tx 0x78,0x56,0x34,0x12 in order; no o_tx_send while i_tx_busy=1.
- 'X' (0x58) -> tx 0x15, o_state returns 0; a following 'R',0x13 reads addr 3.
- 'G' with model busy high 100 cycles -> one o_start pulse, 0x06 only after busy falls. A second 'G' sent while busy -> 0x15.
- i_Rst asserted after 'W',0x01 and 2 data bytes -> no o_mem_we, all outputs 0; the next full 'W' writes correctly.
- BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=100: 'W',0x01 then 101 silent cycles -> tx 0x15, no write. Without the macro: no tx after 1000 cycles.
